// File: rtl/replacement_pkg.sv
// Shared types and constants for the cache replacement engine.
package replacement_pkg;

  typedef enum logic [1:0] {
    POL_FIFO   = 2'd0,
    POL_PLRU   = 2'd1,
    POL_RANDOM = 2'd2
  } policy_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  localparam int LFSR_W = 16;
  // Taps x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/replacement_engine_plru_tree.sv
// Combinational tree-PLRU helper: victim walk and touch update for one set.
// Tree bits are in heap order (node 0 = root, children 2i+1 / 2i+2);
// a 0 bit points the victim into the lower half below that node.
module plru_tree #(
  parameter int WAY_COUNT = 4
) (
  input  logic [WAY_COUNT-2:0]         tree,
  input  logic [$clog2(WAY_COUNT)-1:0] touch_way,
  output logic [$clog2(WAY_COUNT)-1:0] victim,
  output logic [WAY_COUNT-2:0]         tree_next
);

  localparam int WAY_W = $clog2(WAY_COUNT);

  logic [WAY_W-1:0] walk_node;
  logic [WAY_W-1:0] touch_node;

  // Follow the tree bits from root to leaf; each bit visited is one victim bit, MSB first.
  always_comb begin
    victim    = '0;
    walk_node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      victim[WAY_W-1-lvl] = tree[walk_node];
      walk_node           = WAY_W'(2 * walk_node + 1 + tree[walk_node]);
    end
  end

  // Walk the touched way's path and make every node on it point away from that way.
  always_comb begin
    tree_next  = tree;
    touch_node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      tree_next[touch_node] = ~touch_way[WAY_W-1-lvl];
      touch_node            = WAY_W'(2 * touch_node + 1 + touch_way[WAY_W-1-lvl]);
    end
  end

endmodule

// File: rtl/replacement_engine.sv
// Per-set victim selector for set-associative caches. The policy is fixed at
// elaboration; an invalid way in the addressed set always wins over it.
// Per-set state lives in a RAM-style array cleared by a one-set-per-cycle sweep.
module replacement_engine
  import replacement_pkg::*;
#(
  parameter int          WAY_COUNT = 4,
  parameter int          SET_COUNT = 64,
  parameter policy_e     POLICY    = POL_PLRU,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(SET_COUNT)-1:0] set,
  input  logic [$clog2(WAY_COUNT)-1:0] way,
  input  logic [WAY_COUNT-1:0]         valid_mask,
  input  logic                         read,
  input  logic                         written,
  input  logic                         taken,
  input  logic                         flush,
  output logic [$clog2(WAY_COUNT)-1:0] replacement_way,
  output logic                         ready
);

  localparam int WAY_W = $clog2(WAY_COUNT);
  localparam int SET_W = $clog2(SET_COUNT);

  fsm_state_e       fsm_state;
  logic [SET_W-1:0] sweep_ctr;
  logic             sweeping;
  logic             accept;
  logic             all_valid;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] policy_way;

  assign sweeping  = (fsm_state == ST_INIT);
  // A flush in the same cycle as an event discards the event; the sweep restarts anyway.
  assign accept    = ready && !flush;
  assign all_valid = &valid_mask;

  // Sweep FSM: walk every set once after reset or flush, then accept events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state <= ST_INIT;
      sweep_ctr <= '0;
      ready     <= 1'b0;
    end else if (flush) begin
      fsm_state <= ST_INIT;
      sweep_ctr <= '0;
      ready     <= 1'b0;
    end else if (fsm_state == ST_INIT) begin
      sweep_ctr <= sweep_ctr + 1'b1;
      if (sweep_ctr == SET_W'(SET_COUNT - 1)) begin
        fsm_state <= ST_RUN;
        ready     <= 1'b1;
      end
    end
  end

  // Lowest-index invalid way; only consulted when some way is invalid.
  always_comb begin
    inv_way = '0;
    for (int i = WAY_COUNT - 1; i >= 0; i--) begin
      if (!valid_mask[i]) inv_way = WAY_W'(i);
    end
  end

  assign replacement_way = !ready    ? '0         :
                           all_valid ? policy_way : inv_way;

  if (POLICY == POL_FIFO) begin : g_fifo
    logic [WAY_W-1:0] fifo_mem [SET_COUNT];
    logic             fifo_adv;

    // Only a fill that evicted a valid line moves the round-robin pointer.
    assign fifo_adv = accept && taken && all_valid;

    // Per-set round-robin pointer; cleared by the sweep, bumped on a policy-chosen fill.
    always_ff @(posedge clk) begin
      if (sweeping) begin
        fifo_mem[sweep_ctr] <= '0;
      end else if (fifo_adv) begin
        fifo_mem[set] <= fifo_mem[set] + 1'b1;
      end
    end

    assign policy_way = fifo_mem[set];

  end else if (POLICY == POL_PLRU) begin : g_plru
    logic [WAY_COUNT-2:0] plru_mem [SET_COUNT];
    logic [WAY_COUNT-2:0] tree_cur;
    logic [WAY_COUNT-2:0] tree_next;
    logic [WAY_W-1:0]     touch_way;
    logic                 plru_upd;

    assign tree_cur  = plru_mem[set];
    // A fill outranks a simultaneous hit: only the filled way is touched.
    assign touch_way = taken ? replacement_way : way;
    assign plru_upd  = accept && (read || written || taken);

    plru_tree #(
      .WAY_COUNT (WAY_COUNT)
    ) u_plru_tree (
      .tree      (tree_cur),
      .touch_way (touch_way),
      .victim    (policy_way),
      .tree_next (tree_next)
    );

    // Per-set PLRU tree; cleared by the sweep, updated by one touch per accepted event.
    always_ff @(posedge clk) begin
      if (sweeping) begin
        plru_mem[sweep_ctr] <= '0;
      end else if (plru_upd) begin
        plru_mem[set] <= tree_next;
      end
    end

  end else begin : g_random
    logic [LFSR_W-1:0] lfsr;

    // Single shared LFSR; restarts only on reset, steps on every accepted fill.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lfsr <= LFSR_SEED;
      end else if (accept && taken) begin
        lfsr <= lfsr_next(lfsr);
      end
    end

    assign policy_way = lfsr[WAY_W-1:0];
  end

endmodule
